// File: rtl/pipe_addsub.sv
// pipe_addsub
//   Pipelined add / subtract / accumulate unit sitting between the operand
//   registers and the result bus. Accepts one operation per cycle, no
//   backpressure. Stage 1 does the arithmetic and owns the accumulator.
//   Stages 2..STAGES are plain delay registers. A final output register
//   presents the result, so a result issued at edge N is on the outputs
//   from edge N+STAGES.
//
// Parameters
//   WIDTH  : operand/result width in bits (2 or more)
//   STAGES : latency in cycles from the sampling edge to the result (1 or more)
//   SAT    : 1 clamps a signed-overflowing result to the signed max/min
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      synchronous active-low reset; beats hold and en
//   en     in   1      operation valid; a, b and op are sampled when set
//   op     in   2      00 a+b, 01 a-b, 10 acc+a, 11 acc=a
//   a      in   WIDTH  first operand
//   b      in   WIDTH  second operand (unused for op 10/11)
//   hold   in   1      freezes every register in the block for the cycle
//   z      out  WIDTH  result
//   carry  out  1      carry (add/acc), borrow (sub), 0 (load)
//   ovf    out  1      signed overflow of the raw result, 0 for load
//   vld    out  1      z/carry/ovf carry a fresh result this cycle

module pipe_addsub #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hold,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             ovf,
  output logic             vld
);

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opnd_x;
  logic [WIDTH-1:0] opnd_y;
  logic [WIDTH:0]   raw;
  logic             raw_carry;
  logic             raw_ovf;
  logic [WIDTH-1:0] res_z;

  logic [STAGES-1:0]            p_vld;
  logic [STAGES-1:0][WIDTH-1:0] p_z;
  logic [STAGES-1:0]            p_carry;
  logic [STAGES-1:0]            p_ovf;

  // Stage-1 arithmetic. Accumulate reuses the adder with acc as the first
  // operand, so the overflow and saturation direction always follow
  // opnd_x. Subtract is done as x + ~y + 1, whose top bit means "no
  // borrow", so it is inverted to report a borrow on carry.
  always_comb begin
    opnd_x    = (op == 2'b10) ? acc : a;
    opnd_y    = (op == 2'b10) ? a   : b;
    raw       = '0;
    raw_carry = 1'b0;
    raw_ovf   = 1'b0;
    case (op)
      2'b00, 2'b10: begin
        raw       = {1'b0, opnd_x} + {1'b0, opnd_y};
        raw_carry = raw[WIDTH];
        raw_ovf   = (opnd_x[WIDTH-1] == opnd_y[WIDTH-1]) &&
                    (raw[WIDTH-1] != opnd_x[WIDTH-1]);
      end
      2'b01: begin
        raw       = {1'b0, opnd_x} + {1'b0, ~opnd_y} + {{WIDTH{1'b0}}, 1'b1};
        raw_carry = ~raw[WIDTH];
        raw_ovf   = (opnd_x[WIDTH-1] != opnd_y[WIDTH-1]) &&
                    (raw[WIDTH-1] != opnd_x[WIDTH-1]);
      end
      default: begin
        raw = {1'b0, a};
      end
    endcase
    res_z = raw[WIDTH-1:0];
    // A negative first operand can only overflow downwards and vice versa.
    if (SAT != 0 && raw_ovf) begin
      res_z = opnd_x[WIDTH-1] ? SMIN : SMAX;
    end
  end

  // All state lives in one process: reset first, then hold freezes
  // everything, otherwise the pipe advances. Data registers only load
  // when a valid result arrives, so z/carry/ovf keep their last valid
  // values through bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_vld   <= '0;
      p_z     <= '0;
      p_carry <= '0;
      p_ovf   <= '0;
      acc     <= '0;
      vld     <= 1'b0;
      z       <= '0;
      carry   <= 1'b0;
      ovf     <= 1'b0;
    end else if (!hold) begin
      p_vld[0] <= en;
      if (en) begin
        p_z[0]     <= res_z;
        p_carry[0] <= raw_carry;
        p_ovf[0]   <= raw_ovf;
        if (op == 2'b10) begin
          acc <= res_z;
        end else if (op == 2'b11) begin
          acc <= a;
        end
      end

      for (int s = 1; s < STAGES; s++) begin
        p_vld[s] <= p_vld[s-1];
        if (p_vld[s-1]) begin
          p_z[s]     <= p_z[s-1];
          p_carry[s] <= p_carry[s-1];
          p_ovf[s]   <= p_ovf[s-1];
        end
      end

      vld <= p_vld[STAGES-1];
      if (p_vld[STAGES-1]) begin
        z     <= p_z[STAGES-1];
        carry <= p_carry[STAGES-1];
        ovf   <= p_ovf[STAGES-1];
      end
    end
  end

endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub
//   Drives four pipe_addsub instances from one shared stimulus:
//     k=0  WIDTH=8  STAGES=2 SAT=0   (directed scenarios)
//     k=1  WIDTH=8  STAGES=2 SAT=1   (saturation scenarios)
//     k=2  WIDTH=16 STAGES=1 SAT=0
//     k=3  WIDTH=32 STAGES=4 SAT=0
//   A reference model computes results with plain integer arithmetic and
//   tracks each in-flight result as "non-held edges still to wait".

module tb_pipe_addsub;

  localparam int NK = 4;
  localparam int W_K   [NK] = '{8, 8, 16, 32};
  localparam int S_K   [NK] = '{2, 2, 1, 4};
  localparam int SAT_K [NK] = '{0, 1, 0, 0};
  localparam int NSLOT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        hold;
  logic [1:0]  op;
  logic [31:0] a32;
  logic [31:0] b32;

  logic [7:0]  z_d8, z_ds;
  logic [15:0] z_d16;
  logic [31:0] z_d32;
  logic        c_d8, c_ds, c_d16, c_d32;
  logic        o_d8, o_ds, o_d16, o_d32;
  logic        v_d8, v_ds, v_d16, v_d32;

  logic [31:0] ob_z [NK];
  logic        ob_v [NK];
  logic        ob_c [NK];
  logic        ob_o [NK];

  int total = 0;
  int bad   = 0;

  longint m_acc     [NK];
  bit     slot_on   [NK][NSLOT];
  int     slot_left [NK][NSLOT];
  longint slot_z    [NK][NSLOT];
  bit     slot_c    [NK][NSLOT];
  bit     slot_o    [NK][NSLOT];
  bit     ex_v [NK];
  bit     ex_c [NK];
  bit     ex_o [NK];
  longint ex_z [NK];

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(8), .STAGES(2), .SAT(0)) u_d8 (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .a(a32[7:0]), .b(b32[7:0]),
    .hold(hold), .z(z_d8), .carry(c_d8), .ovf(o_d8), .vld(v_d8));

  pipe_addsub #(.WIDTH(8), .STAGES(2), .SAT(1)) u_ds (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .a(a32[7:0]), .b(b32[7:0]),
    .hold(hold), .z(z_ds), .carry(c_ds), .ovf(o_ds), .vld(v_ds));

  pipe_addsub #(.WIDTH(16), .STAGES(1), .SAT(0)) u_d16 (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .a(a32[15:0]), .b(b32[15:0]),
    .hold(hold), .z(z_d16), .carry(c_d16), .ovf(o_d16), .vld(v_d16));

  pipe_addsub #(.WIDTH(32), .STAGES(4), .SAT(0)) u_d32 (
    .clk(clk), .rst_n(rst_n), .en(en), .op(op), .a(a32), .b(b32),
    .hold(hold), .z(z_d32), .carry(c_d32), .ovf(o_d32), .vld(v_d32));

  assign ob_z[0] = {24'd0, z_d8};
  assign ob_z[1] = {24'd0, z_ds};
  assign ob_z[2] = {16'd0, z_d16};
  assign ob_z[3] = z_d32;
  assign ob_v[0] = v_d8;  assign ob_c[0] = c_d8;  assign ob_o[0] = o_d8;
  assign ob_v[1] = v_ds;  assign ob_c[1] = c_ds;  assign ob_o[1] = o_ds;
  assign ob_v[2] = v_d16; assign ob_c[2] = c_d16; assign ob_o[2] = o_d16;
  assign ob_v[3] = v_d32; assign ob_c[3] = c_d32; assign ob_o[3] = o_d32;

  // Reference arithmetic: unsigned view for z/carry, signed view for
  // overflow and the saturation direction.
  function automatic void model_calc(input int k, input logic [1:0] f_op,
                                     input logic [31:0] fa, input logic [31:0] fb,
                                     output longint rz, output bit rc, output bit ro);
    longint w, mask, half, ua, ub, x, y, sx, sy, sr;
    w    = W_K[k];
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = {32'd0, fa} & mask;
    ub   = {32'd0, fb} & mask;
    x    = (f_op == 2'b10) ? m_acc[k] : ua;
    y    = (f_op == 2'b10) ? ua : ub;
    sx   = (x >= half) ? x - 2 * half : x;
    sy   = (y >= half) ? y - 2 * half : y;
    case (f_op)
      2'b00, 2'b10: begin
        rz = (x + y) & mask;
        rc = (x + y) > mask;
        sr = sx + sy;
      end
      2'b01: begin
        rz = (x - y) & mask;
        rc = (x < y);
        sr = sx - sy;
      end
      default: begin
        rz = ua;
        rc = 1'b0;
        sr = 0;
      end
    endcase
    ro = (f_op != 2'b11) && (sr > half - 1 || sr < -half);
    if (SAT_K[k] != 0 && ro) rz = (sr > 0) ? half - 1 : half;
  endfunction

  // Advances the model by one clock edge using the inputs presented there.
  task automatic model_edge();
    bit     shown;
    bit     placed;
    longint rz;
    bit     rc, ro;
    for (int k = 0; k < NK; k++) begin
      if (!rst_n) begin
        m_acc[k] = 0;
        for (int s = 0; s < NSLOT; s++) slot_on[k][s] = 1'b0;
        ex_v[k] = 1'b0; ex_z[k] = 0; ex_c[k] = 1'b0; ex_o[k] = 1'b0;
      end else if (!hold) begin
        shown = 1'b0;
        for (int s = 0; s < NSLOT; s++) begin
          if (slot_on[k][s]) begin
            slot_left[k][s]--;
            if (slot_left[k][s] == 0) begin
              ex_v[k] = 1'b1;
              ex_z[k] = slot_z[k][s];
              ex_c[k] = slot_c[k][s];
              ex_o[k] = slot_o[k][s];
              slot_on[k][s] = 1'b0;
              shown = 1'b1;
            end
          end
        end
        if (!shown) ex_v[k] = 1'b0;
        if (en) begin
          model_calc(k, op, a32, b32, rz, rc, ro);
          placed = 1'b0;
          for (int s = 0; s < NSLOT; s++) begin
            if (!placed && !slot_on[k][s]) begin
              slot_on[k][s]   = 1'b1;
              slot_left[k][s] = S_K[k];
              slot_z[k][s]    = rz;
              slot_c[k][s]    = rc;
              slot_o[k][s]    = ro;
              placed = 1'b1;
            end
          end
          if (op == 2'b10) m_acc[k] = rz;
          else if (op == 2'b11) m_acc[k] = {32'd0, a32} & ((longint'(1) << W_K[k]) - 1);
        end
      end
    end
  endtask

  // One clock edge: model follows the edge, outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic t_en, input logic [1:0] t_op,
                       input logic [31:0] t_a, input logic [31:0] t_b,
                       input logic t_hold);
    en = t_en; op = t_op; a32 = t_a; b32 = t_b; hold = t_hold;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 2'b11, 32'h0000_00AA, 32'h0000_0011, 1'b0);
    tick();
    tick();
    for (int k = 0; k < NK; k++) begin
      total++;
      if (ob_v[k] !== 1'b0 || ob_z[k] !== 32'd0 || ob_c[k] !== 1'b0 || ob_o[k] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL reset k=%0d: vld=%b z=%h carry=%b ovf=%b, want all 0",
                 k, ob_v[k], ob_z[k], ob_c[k], ob_o[k]);
      end
    end
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    total++;
    if (v_d8 !== 1'b0 || z_d8 !== 8'h00) begin
      bad++;
      $display("[TB] FAIL after_release: vld=%b z=%h, want 0 00", v_d8, z_d8);
    end
  endtask

  task automatic test_add();
    drive(1'b1, 2'b00, 32'h0000_00F0, 32'h0000_0020, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    total++;
    if (v_d8 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL add_early: vld=%b, want 0", v_d8);
    end
    tick();
    total++;
    if (v_d8 !== 1'b1 || z_d8 !== 8'h10 || c_d8 !== 1'b1 || o_d8 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL add: vld=%b z=%h carry=%b ovf=%b, want 1 10 1 0", v_d8, z_d8, c_d8, o_d8);
    end
    tick();
    total++;
    if (v_d8 !== 1'b0 || z_d8 !== 8'h10 || c_d8 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL add_after: vld=%b z=%h carry=%b, want 0 10 1", v_d8, z_d8, c_d8);
    end
  endtask

  task automatic test_sub();
    drive(1'b1, 2'b01, 32'h0000_0010, 32'h0000_0020, 1'b0);
    tick();
    drive(1'b1, 2'b01, 32'h0000_0080, 32'h0000_0001, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    total++;
    if (v_d8 !== 1'b1 || z_d8 !== 8'hF0 || c_d8 !== 1'b1 || o_d8 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sub_borrow: vld=%b z=%h carry=%b ovf=%b, want 1 f0 1 0", v_d8, z_d8, c_d8, o_d8);
    end
    tick();
    total++;
    if (v_d8 !== 1'b1 || z_d8 !== 8'h7F || c_d8 !== 1'b0 || o_d8 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sub_ovf: vld=%b z=%h carry=%b ovf=%b, want 1 7f 0 1", v_d8, z_d8, c_d8, o_d8);
    end
    tick();
    total++;
    if (v_d8 !== 1'b0 || z_d8 !== 8'h7F) begin
      bad++;
      $display("[TB] FAIL sub_after: vld=%b z=%h, want 0 7f", v_d8, z_d8);
    end
  endtask

  task automatic test_accumulate();
    logic [7:0] want [4];
    want[0] = 8'h05; want[1] = 8'h08; want[2] = 8'h0B; want[3] = 8'h0E;
    for (int e = 0; e < 7; e++) begin
      if (e == 0)     drive(1'b1, 2'b11, 32'h0000_0005, $urandom, 1'b0);
      else if (e < 4) drive(1'b1, 2'b10, 32'h0000_0003, $urandom, 1'b0);
      else            drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
      tick();
      total++;
      if (e >= 2 && e <= 5) begin
        if (v_d8 !== 1'b1 || z_d8 !== want[e-2]) begin
          bad++;
          $display("[TB] FAIL accumulate e=%0d: vld=%b z=%h, want 1 %h", e, v_d8, z_d8, want[e-2]);
        end
      end else if (v_d8 !== 1'b0) begin
        bad++;
        $display("[TB] FAIL accumulate_idle e=%0d: vld=%b, want 0", e, v_d8);
      end
    end
  endtask

  task automatic test_hold();
    drive(1'b1, 2'b00, 32'h0000_0001, 32'h0000_0002, 1'b0);
    tick();
    for (int h = 0; h < 3; h++) begin
      // an operation offered during hold must be lost
      drive(1'b1, 2'b00, 32'h0000_0055, 32'h0000_0055, 1'b1);
      tick();
      total++;
      if (v_d8 !== 1'b0 || z_d8 !== 8'h0E) begin
        bad++;
        $display("[TB] FAIL hold_frozen h=%0d: vld=%b z=%h, want 0 0e", h, v_d8, z_d8);
      end
    end
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    total++;
    if (v_d8 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold_early: vld=%b, want 0", v_d8);
    end
    tick();
    total++;
    if (v_d8 !== 1'b1 || z_d8 !== 8'h03 || c_d8 !== 1'b0 || o_d8 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL hold_result: vld=%b z=%h carry=%b ovf=%b, want 1 03 0 0", v_d8, z_d8, c_d8, o_d8);
    end
    tick();
    total++;
    if (v_d8 !== 1'b0 || z_d8 !== 8'h03) begin
      bad++;
      $display("[TB] FAIL hold_lost_op: vld=%b z=%h, want 0 03", v_d8, z_d8);
    end
    // hold while a result is on the outputs keeps it there
    drive(1'b1, 2'b00, 32'h0000_0004, 32'h0000_0005, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b1);
    tick();
    total++;
    if (v_d8 !== 1'b1 || z_d8 !== 8'h09) begin
      bad++;
      $display("[TB] FAIL hold_vld_frozen: vld=%b z=%h, want 1 09", v_d8, z_d8);
    end
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    total++;
    if (v_d8 !== 1'b0 || z_d8 !== 8'h09) begin
      bad++;
      $display("[TB] FAIL hold_release: vld=%b z=%h, want 0 09", v_d8, z_d8);
    end
  endtask

  task automatic test_reset_mid_flight();
    drive(1'b1, 2'b00, 32'h0000_0011, 32'h0000_0022, 1'b0);
    tick();
    drive(1'b1, 2'b00, 32'h0000_0033, 32'h0000_0044, 1'b0);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 2'b10, 32'h0000_0077, 32'd0, 1'b1);
    tick();
    total++;
    if (v_d8 !== 1'b0 || z_d8 !== 8'h00 || c_d8 !== 1'b0 || o_d8 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midreset: vld=%b z=%h carry=%b ovf=%b, want 0 00 0 0", v_d8, z_d8, c_d8, o_d8);
    end
    rst_n = 1'b1;
    drive(1'b1, 2'b10, 32'h0000_0002, 32'd0, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    for (int e = 0; e < 3; e++) begin
      total++;
      if (v_d8 !== 1'b0 || z_d8 !== 8'h00) begin
        bad++;
        $display("[TB] FAIL midreset_dropped e=%0d: vld=%b z=%h, want 0 00", e, v_d8, z_d8);
      end
      tick();
      if (e == 1) begin
        total++;
        if (v_d8 !== 1'b1 || z_d8 !== 8'h02) begin
          bad++;
          $display("[TB] FAIL midreset_acc: vld=%b z=%h, want 1 02", v_d8, z_d8);
        end
        break;
      end
    end
  endtask

  task automatic test_saturation();
    drive(1'b1, 2'b00, 32'h0000_007F, 32'h0000_0001, 1'b0);
    tick();
    drive(1'b1, 2'b00, 32'h0000_0080, 32'h0000_00FF, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    tick();
    total++;
    if (v_ds !== 1'b1 || z_ds !== 8'h7F || c_ds !== 1'b0 || o_ds !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sat_pos: vld=%b z=%h carry=%b ovf=%b, want 1 7f 0 1", v_ds, z_ds, c_ds, o_ds);
    end
    total++;
    if (z_d8 !== 8'h80 || o_d8 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL nosat_pos: z=%h ovf=%b, want 80 1", z_d8, o_d8);
    end
    tick();
    total++;
    if (v_ds !== 1'b1 || z_ds !== 8'h80 || c_ds !== 1'b1 || o_ds !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sat_neg: vld=%b z=%h carry=%b ovf=%b, want 1 80 1 1", v_ds, z_ds, c_ds, o_ds);
    end
    total++;
    if (z_d8 !== 8'h7F || c_d8 !== 1'b1 || o_d8 !== 1'b1) begin
      bad++;
      $display("[TB] FAIL nosat_neg: z=%h carry=%b ovf=%b, want 7f 1 1", z_d8, c_d8, o_d8);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cyc < 64) begin
        rst_n = (cyc != 40);
        drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, $urandom,
              $urandom_range(0, 4) == 0);
      end else begin
        rst_n = 1'b1;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
      end
      tick();
      for (int k = 0; k < NK; k++) begin
        total++;
        if (ob_v[k] !== ex_v[k] || ob_c[k] !== ex_c[k] || ob_o[k] !== ex_o[k] ||
            ob_z[k] !== ex_z[k][31:0]) begin
          bad++;
          $display("[TB] FAIL random cyc=%0d k=%0d: vld=%b z=%h carry=%b ovf=%b, want %b %h %b %b",
                   cyc, k, ob_v[k], ob_z[k], ob_c[k], ob_o[k],
                   ex_v[k], ex_z[k][31:0], ex_c[k], ex_o[k]);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NK; k++) begin
      m_acc[k] = 0; ex_v[k] = 1'b0; ex_z[k] = 0; ex_c[k] = 1'b0; ex_o[k] = 1'b0;
      for (int s = 0; s < NSLOT; s++) begin
        slot_on[k][s] = 1'b0; slot_left[k][s] = 0; slot_z[k][s] = 0;
        slot_c[k][s] = 1'b0; slot_o[k][s] = 1'b0;
      end
    end
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    test_reset();
    test_add();
    test_sub();
    test_accumulate();
    test_hold();
    test_reset_mid_flight();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
